// File: rtl/uart_image_ctrl_pkg.sv
// uart_image_pkg
// Shared encodings for the UART image loader controller.
//   state_t    : top-level agent that owns the frame RAM
//                (LOAD = UART RX writes, IDLE = processor reads, DUMP = UART TX reads)
//   dump_sub_t : per-byte sequencing inside DUMP
// No ports; imported by uart_image_ctrl.
package uart_image_pkg;

    typedef enum logic [1:0] {
        ST_LOAD = 2'b00,
        ST_IDLE = 2'b01,
        ST_DUMP = 2'b10
    } state_t;

    // D_ADDR presents the address, D_WAIT covers the RAM read latency,
    // D_SEND hands the byte to uart_tx, D_BUSY waits for its completion.
    typedef enum logic [1:0] {
        D_ADDR = 2'b00,
        D_WAIT = 2'b01,
        D_SEND = 2'b10,
        D_BUSY = 2'b11
    } dump_sub_t;

endpackage

// File: rtl/uart_image_ctrl_edge_rise.sv
// edge_rise
// Registered rising-edge detector for synchronous level inputs.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   sig   : synchronous level input
//   rise  : high for the one cycle in which sig is high and was low the cycle before
// The history flop resets to 1 so a level held high through reset gives no edge.
module edge_rise (
    input  logic clk,
    input  logic rst_n,
    input  logic sig,
    output logic rise
);

    logic prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev <= 1'b1;
        end else begin
            prev <= sig;
        end
    end

    assign rise = sig & ~prev;

endmodule

// File: rtl/uart_image_ctrl.sv
// uart_image_ctrl
// Owns the single-port frame RAM and hands it to one of three agents:
// the UART RX byte stream (LOAD), the processor/display port (IDLE) and the
// UART TX byte stream (DUMP). Images are DEPTH bytes starting at BASE_ADDR.
//
// Optional build macro: UART_IMG_CSUM_EN
//   When defined, a csum port exposes the modulo-2**DATA_W sum of the last
//   loaded image and a dump appends that sum as one extra final byte.
//
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   rx_dv, rx_byte        : received byte strobe and data from uart_rx
//   tx_start, tx_byte     : transmit strobe and held byte to uart_tx
//   tx_done               : byte-sent strobe from uart_tx
//   start_dump, reload    : levels; rising edges request dump / new load
//   proc_addr             : processor read address, routed to RAM in IDLE
//   ram_addr/wdata/wren   : registered RAM controls
//   ram_rdata             : RAM q, valid one cycle after ram_addr
//   state_o               : 00 LOAD, 01 IDLE, 10 DUMP
//   load_done, dump_done  : one-cycle completion pulses
//   rx_drop               : sticky flag, bytes received outside LOAD
//   csum                  : (UART_IMG_CSUM_EN only) checksum of last load
module uart_image_ctrl
    import uart_image_pkg::*;
#(
    parameter int ADDR_W    = 18,
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 262144,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_dv,
    input  logic [DATA_W-1:0] rx_byte,
    output logic              tx_start,
    output logic [DATA_W-1:0] tx_byte,
    input  logic              tx_done,
    input  logic              start_dump,
    input  logic              reload,
    input  logic [ADDR_W-1:0] proc_addr,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [1:0]        state_o,
    output logic              load_done,
    output logic              dump_done,
    output logic              rx_drop
`ifdef UART_IMG_CSUM_EN
    ,
    output logic [DATA_W-1:0] csum
`endif
);

    // One spare pointer bit lets the checksum slot sit at offset DEPTH even
    // when the image fills the whole address space.
    localparam int PTR_W = ADDR_W + 1;
    localparam logic [PTR_W-1:0]  LAST_RAM = PTR_W'(DEPTH - 1);
`ifdef UART_IMG_CSUM_EN
    localparam logic [PTR_W-1:0]  LAST_SEND = PTR_W'(DEPTH);
`else
    localparam logic [PTR_W-1:0]  LAST_SEND = LAST_RAM;
`endif
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    state_t            state, state_n;
    dump_sub_t         dsub, dsub_n;
    logic [PTR_W-1:0]  ptr, ptr_n;
    logic [ADDR_W-1:0] ram_addr_n;
    logic [ADDR_W-1:0] ptr_addr;
    logic [DATA_W-1:0] ram_wdata_n;
    logic [DATA_W-1:0] tx_byte_n;
    logic              ram_wren_n;
    logic              tx_start_n;
    logic              load_done_n;
    logic              dump_done_n;
    logic              rx_drop_n;
    logic              dump_edge;
    logic              reload_edge;
`ifdef UART_IMG_CSUM_EN
    logic [DATA_W-1:0] sum, sum_n;
    assign csum = sum;
`endif

    edge_rise u_dump_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .sig   (start_dump),
        .rise  (dump_edge)
    );

    edge_rise u_reload_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .sig   (reload),
        .rise  (reload_edge)
    );

    assign ptr_addr = BASE + ptr[ADDR_W-1:0];
    assign state_o  = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_LOAD;
            dsub      <= D_ADDR;
            ptr       <= '0;
            ram_addr  <= BASE;
            ram_wdata <= '0;
            ram_wren  <= 1'b0;
            tx_start  <= 1'b0;
            tx_byte   <= '0;
            load_done <= 1'b0;
            dump_done <= 1'b0;
            rx_drop   <= 1'b0;
`ifdef UART_IMG_CSUM_EN
            sum       <= '0;
`endif
        end else begin
            state     <= state_n;
            dsub      <= dsub_n;
            ptr       <= ptr_n;
            ram_addr  <= ram_addr_n;
            ram_wdata <= ram_wdata_n;
            ram_wren  <= ram_wren_n;
            tx_start  <= tx_start_n;
            tx_byte   <= tx_byte_n;
            load_done <= load_done_n;
            dump_done <= dump_done_n;
            rx_drop   <= rx_drop_n;
`ifdef UART_IMG_CSUM_EN
            sum       <= sum_n;
`endif
        end
    end

    // Every RAM/UART output is computed here and registered above, so a
    // strobe seen in cycle N shows up on the outputs in cycle N+1.
    always_comb begin
        state_n     = state;
        dsub_n      = dsub;
        ptr_n       = ptr;
        ram_addr_n  = ram_addr;
        ram_wdata_n = ram_wdata;
        ram_wren_n  = 1'b0;
        tx_start_n  = 1'b0;
        tx_byte_n   = tx_byte;
        load_done_n = 1'b0;
        dump_done_n = 1'b0;
        rx_drop_n   = rx_drop;
`ifdef UART_IMG_CSUM_EN
        sum_n       = sum;
`endif

        case (state)
            ST_LOAD: begin
                if (rx_dv) begin
                    ram_wren_n  = 1'b1;
                    ram_wdata_n = rx_byte;
                    ram_addr_n  = ptr_addr;
`ifdef UART_IMG_CSUM_EN
                    sum_n       = sum + rx_byte;
`endif
                    if (ptr == LAST_RAM) begin
                        load_done_n = 1'b1;
                        ptr_n       = '0;
                        state_n     = ST_IDLE;
                    end else begin
                        ptr_n = ptr + PTR_W'(1);
                    end
                end
            end

            ST_IDLE: begin
                ram_addr_n = proc_addr;
                // Dump has priority; a simultaneous reload edge is dropped.
                if (dump_edge) begin
                    state_n = ST_DUMP;
                    dsub_n  = D_ADDR;
                    ptr_n   = '0;
                end else if (reload_edge) begin
                    state_n   = ST_LOAD;
                    ptr_n     = '0;
                    rx_drop_n = 1'b0;
`ifdef UART_IMG_CSUM_EN
                    sum_n     = '0;
`endif
                end
            end

            ST_DUMP: begin
                case (dsub)
                    D_ADDR: begin
                        ram_addr_n = ptr_addr;
                        dsub_n     = D_WAIT;
                    end
                    D_WAIT: begin
                        dsub_n = D_SEND;
                    end
                    D_SEND: begin
                        tx_byte_n  = ram_rdata;
`ifdef UART_IMG_CSUM_EN
                        if (ptr == LAST_SEND) begin
                            tx_byte_n = sum;
                        end
`endif
                        tx_start_n = 1'b1;
                        dsub_n     = D_BUSY;
                    end
                    D_BUSY: begin
                        if (tx_done) begin
                            if (ptr == LAST_SEND) begin
                                dump_done_n = 1'b1;
                                ptr_n       = '0;
                                state_n     = ST_IDLE;
                                dsub_n      = D_ADDR;
                            end else begin
                                ptr_n  = ptr + PTR_W'(1);
                                dsub_n = D_ADDR;
                            end
                        end
                    end
                    default: dsub_n = D_ADDR;
                endcase
            end

            default: state_n = ST_LOAD;
        endcase

        // A byte arriving when nobody is loading is lost; remember that.
        if (rx_dv && (state != ST_LOAD)) begin
            rx_drop_n = 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_image_ctrl.sv
// tb_uart_image_ctrl
// Directed self-checking bench for uart_image_ctrl with DEPTH=4, BASE_ADDR=16.
// Models the external frame RAM (1-cycle read latency) and the uart_tx handshake.
// Build with UART_IMG_CSUM_EN defined to also exercise the checksum byte.
module tb_uart_image_ctrl;

    localparam int ADDR_W    = 8;
    localparam int DATA_W    = 8;
    localparam int DEPTH     = 4;
    localparam int BASE_ADDR = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              rx_dv;
    logic [DATA_W-1:0] rx_byte;
    logic              tx_start;
    logic [DATA_W-1:0] tx_byte;
    logic              tx_done;
    logic              start_dump;
    logic              reload;
    logic [ADDR_W-1:0] proc_addr;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_wren;
    logic [DATA_W-1:0] ram_rdata;
    logic [1:0]        state_o;
    logic              load_done;
    logic              dump_done;
    logic              rx_drop;
`ifdef UART_IMG_CSUM_EN
    logic [DATA_W-1:0] csum;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    logic [7:0] exp_img [4];
    logic [7:0] exp_sum;
    logic [7:0] mem [0:255];

    uart_image_ctrl #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .BASE_ADDR (BASE_ADDR)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_dv      (rx_dv),
        .rx_byte    (rx_byte),
        .tx_start   (tx_start),
        .tx_byte    (tx_byte),
        .tx_done    (tx_done),
        .start_dump (start_dump),
        .reload     (reload),
        .proc_addr  (proc_addr),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_wren   (ram_wren),
        .ram_rdata  (ram_rdata),
        .state_o    (state_o),
        .load_done  (load_done),
        .dump_done  (dump_done),
        .rx_drop    (rx_drop)
`ifdef UART_IMG_CSUM_EN
        ,
        .csum       (csum)
`endif
    );

    always #5 clk = ~clk;

    // Frame RAM model: synchronous write, registered read (q one cycle after address).
    always @(posedge clk) begin
        if (ram_wren) begin
            mem[ram_addr] <= ram_wdata;
        end
        ram_rdata <= mem[ram_addr];
    end

    // Loads exp_img as four rx_dv strobes and checks each registered write.
    task automatic load_image();
        exp_sum = 8'h00;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            rx_dv   = 1'b1;
            rx_byte = exp_img[i];
            @(negedge clk);
            rx_dv   = 1'b0;
            exp_sum = exp_sum + exp_img[i];
            tests_run++;
            if ({ram_wren, ram_wdata, ram_addr, load_done} !==
                {1'b1, exp_img[i], 8'(BASE_ADDR + i), (i == 3)}) begin
                tests_failed++;
                $display("[TB] FAIL load_write[%0d]: got wren=%b data=%h addr=%0d done=%b, expected wren=1 data=%h addr=%0d done=%b",
                         i, ram_wren, ram_wdata, ram_addr, load_done, exp_img[i], BASE_ADDR + i, (i == 3));
            end
        end
        tests_run++;
        if (state_o !== 2'b01) begin
            tests_failed++;
            $display("[TB] FAIL load_state: got %b, expected 01", state_o);
        end
        @(negedge clk);
        tests_run++;
        if ({ram_wren, load_done} !== 2'b00) begin
            tests_failed++;
            $display("[TB] FAIL load_pulse_width: got wren=%b done=%b, expected 0 0", ram_wren, load_done);
        end
    endtask

    // Plays the uart_tx side of a dump that has already been requested.
    task automatic serve_dump();
        int         n;
        logic [7:0] exp;
        logic       got;
        logic       quiet;
`ifdef UART_IMG_CSUM_EN
        n = DEPTH + 1;
`else
        n = DEPTH;
`endif
        for (int b = 0; b < n; b++) begin
            exp = (b < DEPTH) ? exp_img[b] : exp_sum;
            got = 1'b0;
            for (int k = 0; k < 30 && !got; k++) begin
                @(negedge clk);
                got = tx_start;
            end
            tests_run++;
            if (!got || tx_byte !== exp) begin
                tests_failed++;
                $display("[TB] FAIL dump_byte[%0d]: got start=%b byte=%h, expected start=1 byte=%h", b, got, tx_byte, exp);
            end
            quiet = 1'b1;
            repeat (3) begin
                @(negedge clk);
                if (tx_start !== 1'b0) quiet = 1'b0;
            end
            tests_run++;
            if ({quiet, tx_byte} !== {1'b1, exp}) begin
                tests_failed++;
                $display("[TB] FAIL dump_hold[%0d]: got quiet=%b byte=%h, expected quiet=1 byte=%h", b, quiet, tx_byte, exp);
            end
            @(negedge clk);
            tx_done = 1'b1;
            @(negedge clk);
            tx_done = 1'b0;
            tests_run++;
            if ({dump_done, state_o} !== ((b == n - 1) ? 3'b1_01 : 3'b0_10)) begin
                tests_failed++;
                $display("[TB] FAIL dump_ack[%0d]: got done=%b state=%b, expected %b", b, dump_done, state_o,
                         (b == n - 1) ? 3'b1_01 : 3'b0_10);
            end
        end
        @(negedge clk);
        tests_run++;
        if (dump_done !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL dump_done_width: got %b, expected 0", dump_done);
        end
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        rx_dv      = 1'b0;
        rx_byte    = 8'h00;
        tx_done    = 1'b0;
        start_dump = 1'b0;
        reload     = 1'b0;
        proc_addr  = 8'h00;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({state_o, ram_addr, ram_wren, ram_wdata, tx_start, tx_byte, load_done, dump_done, rx_drop} !==
            {2'b00, 8'd16, 1'b0, 8'h00, 1'b0, 8'h00, 3'b000}) begin
            tests_failed++;
            $display("[TB] FAIL reset_values: got st=%b addr=%0d wren=%b wd=%h ts=%b tb=%h ld=%b dd=%b drop=%b, expected st=00 addr=16 rest 0",
                     state_o, ram_addr, ram_wren, ram_wdata, tx_start, tx_byte, load_done, dump_done, rx_drop);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_load();
        exp_img = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        load_image();
    endtask

    task automatic test_dump();
        @(negedge clk);
        start_dump = 1'b1;
        serve_dump();
        start_dump = 1'b0;
    endtask

    task automatic test_idle();
        @(negedge clk);
        proc_addr = 8'd18;
        @(negedge clk);
        tests_run++;
        if ({ram_addr, ram_wren} !== {8'd18, 1'b0}) begin
            tests_failed++;
            $display("[TB] FAIL idle_proc_addr18: got addr=%0d wren=%b, expected addr=18 wren=0", ram_addr, ram_wren);
        end
        proc_addr = 8'd3;
        @(negedge clk);
        tests_run++;
        if (ram_addr !== 8'd3) begin
            tests_failed++;
            $display("[TB] FAIL idle_proc_addr3: got %0d, expected 3", ram_addr);
        end
        rx_dv   = 1'b1;
        rx_byte = 8'h55;
        @(negedge clk);
        rx_dv = 1'b0;
        tests_run++;
        if ({ram_wren, rx_drop} !== 2'b01) begin
            tests_failed++;
            $display("[TB] FAIL idle_rx_drop: got wren=%b drop=%b, expected wren=0 drop=1", ram_wren, rx_drop);
        end
        repeat (3) @(negedge clk);
        tests_run++;
        if ({rx_drop, mem[16], mem[17], mem[18], mem[19]} !== {1'b1, 32'hA1B2C3D4}) begin
            tests_failed++;
            $display("[TB] FAIL idle_sticky_ram: got drop=%b ram=%h%h%h%h, expected drop=1 ram=a1b2c3d4",
                     rx_drop, mem[16], mem[17], mem[18], mem[19]);
        end
    endtask

    task automatic test_simultaneous();
        @(negedge clk);
        start_dump = 1'b1;
        reload     = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({state_o, rx_drop} !== 3'b10_1) begin
            tests_failed++;
            $display("[TB] FAIL both_edges: got state=%b drop=%b, expected state=10 drop=1", state_o, rx_drop);
        end
        serve_dump();
        tests_run++;
        if ({state_o, rx_drop} !== 3'b01_1) begin
            tests_failed++;
            $display("[TB] FAIL both_edges_after: got state=%b drop=%b, expected state=01 drop=1", state_o, rx_drop);
        end
        start_dump = 1'b0;
        reload     = 1'b0;
    endtask

    task automatic test_reload();
        @(negedge clk);
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        tests_run++;
        if ({state_o, rx_drop} !== 3'b00_0) begin
            tests_failed++;
            $display("[TB] FAIL reload_edge: got state=%b drop=%b, expected state=00 drop=0", state_o, rx_drop);
        end
    endtask

    task automatic test_reset_midload();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            rx_dv   = 1'b1;
            rx_byte = (i == 0) ? 8'h11 : 8'h22;
            @(negedge clk);
            rx_dv = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({state_o, ram_addr, ram_wren, ram_wdata, tx_start, tx_byte, load_done, dump_done, rx_drop} !==
            {2'b00, 8'd16, 1'b0, 8'h00, 1'b0, 8'h00, 3'b000}) begin
            tests_failed++;
            $display("[TB] FAIL midload_reset: got st=%b addr=%0d wren=%b wd=%h ts=%b tb=%h ld=%b dd=%b drop=%b, expected st=00 addr=16 rest 0",
                     state_o, ram_addr, ram_wren, ram_wdata, tx_start, tx_byte, load_done, dump_done, rx_drop);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_img = '{8'h31, 8'h42, 8'h53, 8'h64};
        load_image();
    endtask

`ifdef UART_IMG_CSUM_EN
    task automatic test_csum();
        tests_run++;
        if (csum !== 8'h2A) begin
            tests_failed++;
            $display("[TB] FAIL csum_prev: got %h, expected 2a", csum);
        end
        test_reload();
        exp_img = '{8'hFF, 8'h02, 8'h00, 8'h01};
        load_image();
        tests_run++;
        if (csum !== 8'h02) begin
            tests_failed++;
            $display("[TB] FAIL csum_value: got %h, expected 02", csum);
        end
        test_dump();
    endtask
`endif

    initial begin
        for (int a = 0; a < 256; a++) mem[a] = 8'h00;
        test_reset();
        test_load();
        test_dump();
        test_idle();
        test_simultaneous();
        test_reload();
        test_reset_midload();
        test_dump();
`ifdef UART_IMG_CSUM_EN
        test_csum();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/uart_image_ctrl.md
Name: uart_image_ctrl

Overview:
Parametrised successor to the single-image UART loader controller. It owns the single-port frame RAM and arbitrates it among three agents: the UART RX byte stream (load), the external processor/display port (idle), and the UART TX byte stream (dump). It adds a configurable image depth and base address, reload after dump, drop/overrun status and an optional checksum. It sits between the uart_rx/uart_tx instances and the frame RAM; the PLL, UART cores and RAM stay outside the block.

Parameters:
ADDR_W, 18, RAM address width.
DATA_W, 8, RAM/UART byte width.
DEPTH, 262144, number of bytes per image (512x512); DEPTH <= 2**ADDR_W.
BASE_ADDR, 0, first RAM address used; BASE_ADDR+DEPTH <= 2**ADDR_W.

Ports:
clk  in  1  system clock (PLL output)
rst_n  in  1  asynchronous active-low reset
rx_dv  in  1  one-cycle strobe, rx_byte valid
rx_byte  in  DATA_W  received byte
tx_start  out  1  one-cycle strobe to uart_tx
tx_byte  out  DATA_W  byte to transmit, held while tx_busy
tx_done  in  1  one-cycle strobe from uart_tx, byte sent
start_dump  in  1  synchronous level; rising edge requests dump
reload  in  1  synchronous level; rising edge requests new load
proc_addr  in  ADDR_W  processor read address (IDLE only)
ram_addr  out  ADDR_W  registered RAM address
ram_wdata  out  DATA_W  registered RAM write data
ram_wren  out  1  registered RAM write enable
ram_rdata  in  DATA_W  RAM q; valid 1 cycle after ram_addr
state_o  out  2  00 LOAD, 01 IDLE, 10 DUMP
load_done  out  1  one-cycle pulse, last byte written
dump_done  out  1  one-cycle pulse, last byte acknowledged by tx_done
rx_drop  out  1  sticky; rx_dv seen outside LOAD; cleared by reload edge

Behaviour:
- Reset: state LOAD, pointer = 0, ram_addr=BASE_ADDR, ram_wren=0, ram_wdata=0, tx_start=0, tx_byte=0, load_done=0, dump_done=0, rx_drop=0. Edge detectors are reset to 1 so a signal held high through reset produces no edge.
- Pointer: ADDR_W-bit offset, 0..DEPTH-1; ram_addr = BASE_ADDR + pointer, registered.
- LOAD: a rx_dv in cycle N gives ram_wren=1, ram_wdata=rx_byte, ram_addr=BASE_ADDR+ptr in cycle N+1 for exactly one cycle, then ptr++. On the write at ptr==DEPTH-1: load_done pulses in the same cycle as that ram_wren, ptr returns to 0, and the state goes to IDLE. start_dump and reload are ignored in LOAD.
- IDLE: ram_addr <= proc_addr every cycle (1-cycle registered latency) and ram_wren=0. A start_dump edge goes to DUMP with ptr=0. A reload edge goes to LOAD with ptr=0 and clears rx_drop. If both edges arrive in the same cycle, dump wins and reload is discarded.
- DUMP substates: D_ADDR drives ram_addr=BASE_ADDR+ptr. D_WAIT waits 1 cycle for RAM latency. D_SEND latches tx_byte=ram_rdata and pulses tx_start for 1 cycle. D_BUSY waits for tx_done; then ptr++ and returns to D_ADDR, or on the last byte pulses dump_done and goes to IDLE.
- tx_done outside D_BUSY is ignored. tx_start never reasserts before tx_done.
- rx_dv outside LOAD: byte discarded, no RAM write, rx_drop=1.
- ram_wren is never asserted outside LOAD.
- rst_n low at any point, including mid-load or mid-dump: immediate return to reset values. Partial data already in RAM is left untouched.

Optional Feature:
UART_IMG_CSUM_EN
- Defined: adds port csum out DATA_W. It holds the modulo-2**DATA_W sum of all bytes written during the last load, cleared at load start. Dump sends DEPTH+1 bytes; the extra final byte is csum, sent after the last RAM byte, and dump_done pulses on its tx_done.
- Undefined: no csum port and no extra byte; exactly DEPTH bytes are sent.

Decomposition:
- Package uart_image_pkg: state encodings (ST_LOAD=2'b00, ST_IDLE=2'b01, ST_DUMP=2'b10) and dump substate encodings.
- One sub-module, edge_rise, instanced twice (start_dump, reload): registered rising-edge detector with rst_n.
- The address pointer and mux stay in the top module.

Test Plan:
- DEPTH=4, BASE_ADDR=16; send 0xA1,0xB2,0xC3,0xD4 -> writes to addresses 16..19 one cycle after each rx_dv; load_done coincides with the 0xD4 write; state_o=01.
- After that load, start_dump edge -> 4 tx_start pulses with tx_byte 0xA1,0xB2,0xC3,0xD4, each gated by tx_done; dump_done after the 4th tx_done; state_o=01.
- In IDLE, proc_addr=18 -> ram_addr=18 next cycle, ram_wren=0; rx_dv 0x55 -> no write, rx_drop=1.
- start_dump and reload rising together in IDLE -> DUMP entered; rx_drop unchanged; reload ignored.
- rst_n low after 2 of 4 load bytes -> all outputs at reset values; a fresh 4-byte load writes from address 16 again.
- UART_IMG_CSUM_EN with bytes 0xFF,0x02,0x00,0x01 -> csum=0x02; dump sends 5 bytes, the last being 0x02.
